// File: rtl/pixel_tap_sampler_if.sv
// Pixel-stream in / sampled-level out bundle between a pixel source and one tap sampler.
// The source drives the pixel stream and observes the tap outputs.
interface pixel_tap_sampler_if;
    logic       pixel_valid;
    logic       line_start;
    logic [7:0] data;
    logic       sample_data;
    logic       sample_strobe;
    logic [7:0] tap_value;
    logic       line_timeout;

    modport master (
        output pixel_valid, line_start, data,
        input  sample_data, sample_strobe, tap_value, line_timeout
    );

    modport slave (
        input  pixel_valid, line_start, data,
        output sample_data, sample_strobe, tap_value, line_timeout
    );
endinterface

// File: rtl/pixel_tap_sampler.sv
// Captures one configured pixel per line and turns it into a debounced 1-bit level
// (hysteresis threshold plus N-consecutive-capture filter) for a frequency analyzer channel.
module pixel_tap_sampler #(
    parameter int         PIXEL_INDEX    = 63,
    parameter int         COUNTER_WIDTH  = 11,
    parameter logic [7:0] THRESHOLD_HIGH = 8'd160,
    parameter logic [7:0] THRESHOLD_LOW  = 8'd96,
    parameter int         FILTER_DEPTH   = 2,
    parameter int         LINE_TIMEOUT   = 100000
) (
    input  logic                 s00_axi_aclk,
    input  logic                 s00_axi_aresetn,
    input  logic                 enable,
    pixel_tap_sampler_if.slave   tap
);

    localparam int TW = $clog2(LINE_TIMEOUT + 1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [COUNTER_WIDTH-1:0] TAP_IDX = COUNTER_WIDTH'(PIXEL_INDEX);
    localparam logic [TW-1:0]            TO_LAST = TW'(LINE_TIMEOUT - 1);
    localparam logic [3:0]               DEPTH   = 4'(FILTER_DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LINE = 2'd1,
        ACTIVE    = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
    logic [TW-1:0]            tmo_cnt_q, tmo_cnt_d;
    logic [3:0]               agree_q, agree_d;
    logic                     captured_q, captured_d;
    logic                     sample_q, sample_d;
    logic                     strobe_q, strobe_d;
    logic [7:0]               tap_q, tap_d;
    logic                     line_to_q, line_to_d;

    logic                     line_ev;
    logic                     take_pixel;
    logic                     capture;
    logic                     level;
    logic [COUNTER_WIDTH-1:0] idx;

    assign line_ev = tap.pixel_valid & tap.line_start;
    assign idx     = line_ev ? '0 : pix_cnt_q;

    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        agree_d    = agree_q;
        captured_d = captured_q;
        sample_d   = sample_q;
        strobe_d   = 1'b0;
        tap_d      = tap_q;
        line_to_d  = line_to_q;
        take_pixel = 1'b0;
        capture    = 1'b0;
        level      = sample_q;

        if (!enable) begin
            state_d    = IDLE;
            pix_cnt_d  = '0;
            tmo_cnt_d  = '0;
            agree_d    = '0;
            captured_d = 1'b0;
            sample_d   = 1'b0;
            tap_d      = '0;
            line_to_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: state_d = WAIT_LINE;
                WAIT_LINE: begin
                    if (line_ev) begin
                        state_d    = ACTIVE;
                        tmo_cnt_d  = '0;
                        take_pixel = 1'b1;
                    end
                end
                ACTIVE: begin
                    // A line start in the timeout cycle keeps the line alive.
                    if (line_ev) begin
                        tmo_cnt_d  = '0;
                        take_pixel = 1'b1;
                    end else if (tmo_cnt_q == TO_LAST) begin
                        state_d    = WAIT_LINE;
                        line_to_d  = 1'b1;
                        tmo_cnt_d  = '0;
                        captured_d = 1'b0;
                        agree_d    = '0;
                    end else begin
                        tmo_cnt_d  = tmo_cnt_q + 1'b1;
                        take_pixel = tap.pixel_valid;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (take_pixel) begin
                pix_cnt_d = (idx == CNT_MAX) ? CNT_MAX : idx + 1'b1;
                if (line_ev) captured_d = 1'b0;
                capture = (idx == TAP_IDX) && (line_ev || !captured_q);
            end

            if (capture) begin
                captured_d = 1'b1;
                tap_d      = tap.data;
                strobe_d   = 1'b1;
                if (tap.data >= THRESHOLD_HIGH)     level = 1'b1;
                else if (tap.data <= THRESHOLD_LOW) level = 1'b0;
                // Level change needs DEPTH consecutive disagreeing captures.
                if (level == sample_q) begin
                    agree_d = '0;
                end else if (agree_q + 4'd1 == DEPTH) begin
                    sample_d = level;
                    agree_d  = '0;
                end else begin
                    agree_d = agree_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q    <= IDLE;
            pix_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            agree_q    <= '0;
            captured_q <= 1'b0;
            sample_q   <= 1'b0;
            strobe_q   <= 1'b0;
            tap_q      <= '0;
            line_to_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            agree_q    <= agree_d;
            captured_q <= captured_d;
            sample_q   <= sample_d;
            strobe_q   <= strobe_d;
            tap_q      <= tap_d;
            line_to_q  <= line_to_d;
        end
    end

    assign tap.sample_data   = sample_q;
    assign tap.sample_strobe = strobe_q;
    assign tap.tap_value     = tap_q;
    assign tap.line_timeout  = line_to_q;

endmodule
